// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC default, opcode/func constants.
package cpu_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FUNC_W = 6;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // Opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [FUNC_W-1:0] FUNC_ADD = 6'h20;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 6'h22;
  localparam logic [FUNC_W-1:0] FUNC_AND = 6'h24;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 6'h25;
  localparam logic [FUNC_W-1:0] FUNC_SLT = 6'h2A;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Next-PC selection: jump over taken branch over sequential.
module pc_next
  import cpu_defs::*;
(
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic [IMM_W-1:0] imm16,
  input  logic [TGT_W-1:0] target26,
  output logic [XLEN-1:0]  next_pc_c
);

  logic [XLEN-1:0] br_off;

  assign br_off = {{(XLEN-IMM_W-2){imm16[IMM_W-1]}}, imm16, 2'b00};

  always_comb begin
    next_pc_c = pc_plus4;
    if (jump) begin
      next_pc_c = {pc_plus4[XLEN-1:XLEN-4], target26, 2'b00};
    end else if (branch && zero) begin
      next_pc_c = pc_plus4 + br_off;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: requests a word at pc, holds it for decode, advances pc on handshake.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    instr,
  output logic [OP_W-1:0]    op,
  output logic [FUNC_W-1:0]  func,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  input  logic               Branch,
  input  logic               Zero,
  input  logic               Jump,
  input  logic [IMM_W-1:0]   imm16,
  input  logic [TGT_W-1:0]   target26,
  output logic [XLEN-1:0]    instr_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, instr_q, count_q;
  logic [XLEN-1:0] pc_d;
  logic            capture, transfer;

  pc_next u_pc_next (
    .pc_plus4  (pc_plus4),
    .branch    (Branch),
    .zero      (Zero),
    .jump      (Jump),
    .imm16     (imm16),
    .target26  (target26),
    .next_pc_c (pc_d)
  );

  // State register; low pc bits forced to zero so pc stays word-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_q <= imem_rdata;
      end
      if (transfer) begin
        pc_q    <= {pc_d[XLEN-1:2], 2'b00};
        count_q <= count_q + XLEN'(1);
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    transfer    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          transfer = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign instr       = instr_q;
  assign op          = instr_q[XLEN-1:XLEN-OP_W];
  assign func        = instr_q[FUNC_W-1:0];
  assign instr_count = count_q;

endmodule
